// File: rtl/mc_seq_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/write-back and guards the memory handshake with a timeout.
module mc_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             ir_we,
    output logic             imm_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_AUIPC
    } cls_t;

    state_t     st_q;
    cls_t       cls_q;
    logic [7:0] wcnt_q;
    cls_t       dec_cls;
    logic       dec_ok;
    logic       retire;
    logic       wait_hit;
    logic       unused_inst;

    // Only the opcode field steers sequencing; the rest feeds the datapath.
    assign unused_inst = ^inst[31:7];

    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        case (inst[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_OPIMM;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // A completing handshake always beats the timeout in the same cycle.
    assign wait_hit = !mem_ready && (wcnt_q == 8'(TIMEOUT - 1));

    assign retire = (st_q == S_EXEC && (cls_q == C_BRANCH || cls_q == C_JAL)) ||
                    (st_q == S_MEM && mem_ready && cls_q == C_STORE) ||
                    (st_q == S_WB);

    assign state = st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= S_IDLE;
            cls_q       <= C_R;
            wcnt_q      <= '0;
            trap        <= 1'b0;
            trap_cause  <= 2'd0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (st_q != S_IDLE && !trap)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)
                instret_cnt <= instret_cnt + CNT_W'(1);
            case (st_q)
                S_IDLE: begin
                    st_q   <= S_FETCH;
                    wcnt_q <= '0;
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        if (st_q == S_FETCH) begin
                            st_q <= S_DECODE;
                        end else if (cls_q == C_STORE) begin
                            st_q   <= S_FETCH;
                            wcnt_q <= '0;
                        end else begin
                            st_q <= S_WB;
                        end
                    end else if (wait_hit) begin
                        st_q       <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd2;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (dec_ok) begin
                        cls_q <= dec_cls;
                        st_q  <= S_EXEC;
                    end else begin
                        st_q       <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: begin
                            st_q   <= S_MEM;
                            wcnt_q <= '0;
                        end
                        C_BRANCH, C_JAL: begin
                            st_q   <= S_FETCH;
                            wcnt_q <= '0;
                        end
                        default: st_q <= S_WB;
                    endcase
                end
                S_WB: begin
                    st_q   <= S_FETCH;
                    wcnt_q <= '0;
                end
                default: st_q <= S_TRAP;
            endcase
        end
    end

    // Strobes come only from state and the class latched at DECODE, so later inst
    // changes cannot disturb them. ALU operand selects are held through MEM/WB so the
    // address and result stay stable while they are consumed.
    always_comb begin
        ir_we     = 1'b0;
        imm_we    = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        if (st_q inside {S_EXEC, S_MEM, S_WB}) begin
            case (cls_q)
                C_OPIMM, C_LOAD, C_STORE: alu_b_sel = 1'b1;
                C_LUI: begin
                    alu_a_sel = 2'd2;
                    alu_b_sel = 1'b1;
                end
                C_AUIPC: begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 1'b1;
                end
                default: ;
            endcase
        end
        case (st_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_DECODE: imm_we = 1'b1;
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    pc_src = 1'b1;
                    pc_we  = br_taken;
                end else if (cls_q == C_JAL) begin
                    pc_src = 1'b1;
                    pc_we  = 1'b1;
                    reg_we = 1'b1;
                    wb_sel = 2'd2;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls_q == C_STORE);
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = (cls_q == C_LOAD) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: expected per-cycle traces are built from instruction-level
// phase lists (fetch waits, memory waits, class) and compared cycle by cycle.
module tb_mc_seq_ctrl;

    localparam int TO = 16;
    localparam int CW = 32;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   inst;
    logic          mem_ready, br_taken;
    logic          ir_we, imm_we, pc_we, pc_src, alu_b_sel, mem_req, mem_we, reg_we, trap;
    logic [1:0]    alu_a_sel, wb_sel, trap_cause;
    logic [2:0]    state;
    logic [CW-1:0] cycle_cnt, instret_cnt;
    logic [17:0]   obs;

    always #5 clk = ~clk;

    mc_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
        .ir_we(ir_we), .imm_we(imm_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .mem_req(mem_req), .mem_we(mem_we),
        .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .trap(trap),
        .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    assign obs = {state, ir_we, imm_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
                  mem_req, mem_we, reg_we, wb_sel, trap, trap_cause};

    typedef struct {
        logic [2:0]  st;
        logic [11:0] stb;
        logic        trp;
        logic [1:0]  cause;
        int          cyc;
        int          ret;
        logic        rdy;
        logic        bt;
        logic [31:0] ins;
    } ent_t;

    ent_t       tq[$];
    int         m_cyc, m_ret;
    int         n_vec = 0, n_err = 0;
    logic [6:0] opc_tab [8];

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got_v, exp_v);
        end
    endtask

    function automatic logic [11:0] mk_sb(input logic ir, input logic imm, input logic pw,
                                          input logic ps, input logic [2:0] ab, input logic rq,
                                          input logic we, input logic rw, input logic [1:0] wb);
        return {ir, imm, pw, ps, ab, rq, we, rw, wb};
    endfunction

    // {alu_a_sel, alu_b_sel} per class: R, OP-IMM, LOAD, STORE, BRANCH, JAL, LUI, AUIPC
    function automatic logic [2:0] alu_sel(input int c);
        case (c)
            1, 2, 3: return 3'b001;
            6:       return 3'b101;
            7:       return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int cls_of(input logic [6:0] op);
        for (int i = 0; i < 8; i++) if (opc_tab[i] == op) return i;
        return -1;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] rw();
        return $urandom;
    endfunction

    task automatic push(input logic [2:0] st, input logic [11:0] s, input logic rdy,
                        input logic bt, input logic [31:0] ins, input bit ret,
                        input logic [1:0] cause);
        ent_t e;
        e.st = st; e.stb = s; e.trp = (st == S_TRAP); e.cause = cause;
        e.cyc = m_cyc; e.ret = m_ret; e.rdy = rdy; e.bt = bt; e.ins = ins;
        tq.push_back(e);
        if (st != S_IDLE && st != S_TRAP) m_cyc++;
        if (ret) m_ret++;
    endtask

    task automatic trap_tail(input logic [1:0] cause, input int n);
        repeat (n) push(S_TRAP, 12'd0, rb(), rb(), rw(), 1'b0, cause);
    endtask

    // w not-ready cycles; TO or more of them end in a timeout trap
    task automatic wait_phase(input logic [2:0] st, input logic [11:0] s, input int w,
                              output bit tr);
        tr = 1'b0;
        for (int k = 0; k < w && k < TO; k++) push(st, s, 1'b0, rb(), rw(), 1'b0, 2'd0);
        if (w >= TO) begin
            trap_tail(2'd2, 8);
            tr = 1'b1;
        end
    endtask

    task automatic add_inst(input logic [31:0] ins, input int wf, input int wm,
                            input logic bt, output bit tr);
        int          c;
        logic [2:0]  ab;
        logic [11:0] s;
        c  = cls_of(ins[6:0]);
        ab = alu_sel(c);
        wait_phase(S_FETCH, mk_sb(0, 0, 0, 0, 3'd0, 1, 0, 0, 2'd0), wf, tr);
        if (tr) return;
        push(S_FETCH, mk_sb(1, 0, 1, 0, 3'd0, 1, 0, 0, 2'd0), 1'b1, rb(), rw(), 1'b0, 2'd0);
        push(S_DECODE, mk_sb(0, 1, 0, 0, 3'd0, 0, 0, 0, 2'd0), rb(), rb(), ins, 1'b0, 2'd0);
        case (c)
            4: push(S_EXEC, mk_sb(0, 0, bt, 1, ab, 0, 0, 0, 2'd0), rb(), bt, rw(), 1'b1, 2'd0);
            5: push(S_EXEC, mk_sb(0, 0, 1, 1, ab, 0, 0, 1, 2'd2), rb(), rb(), rw(), 1'b1, 2'd0);
            2, 3: begin
                push(S_EXEC, mk_sb(0, 0, 0, 0, ab, 0, 0, 0, 2'd0), rb(), rb(), rw(), 1'b0, 2'd0);
                s = mk_sb(0, 0, 0, 0, ab, 1, c == 3, 0, 2'd0);
                wait_phase(S_MEM, s, wm, tr);
                if (tr) return;
                push(S_MEM, s, 1'b1, rb(), rw(), c == 3, 2'd0);
                if (c == 2)
                    push(S_WB, mk_sb(0, 0, 0, 0, ab, 0, 0, 1, 2'd1), rb(), rb(), rw(), 1'b1, 2'd0);
            end
            default: begin
                push(S_EXEC, mk_sb(0, 0, 0, 0, ab, 0, 0, 0, 2'd0), rb(), rb(), rw(), 1'b0, 2'd0);
                push(S_WB, mk_sb(0, 0, 0, 0, ab, 0, 0, 1, 2'd0), rb(), rb(), rw(), 1'b1, 2'd0);
            end
        endcase
    endtask

    task automatic add_illegal(input logic [31:0] ins);
        push(S_FETCH, mk_sb(1, 0, 1, 0, 3'd0, 1, 0, 0, 2'd0), 1'b1, rb(), rw(), 1'b0, 2'd0);
        push(S_DECODE, mk_sb(0, 1, 0, 0, 3'd0, 0, 0, 0, 2'd0), rb(), rb(), ins, 1'b0, 2'd0);
        trap_tail(2'd1, 20);
    endtask

    function automatic logic [31:0] rand_ins(input int c);
        logic [31:0] r;
        r = rw();
        return {r[31:7], opc_tab[c]};
    endfunction

    function automatic int pick_wait();
        int v;
        v = $urandom_range(0, 39);
        if (v < 34) return v % 4;
        if (v < 38) return TO - 1;
        return TO;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = rb(); br_taken = rb(); inst = rw();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(obs), 64'd0);
        chk("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("reset_instret", 64'(instret_cnt), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tq.delete();
        m_cyc = 0;
        m_ret = 0;
        push(S_IDLE, 12'd0, rb(), rb(), rw(), 1'b0, 2'd0);
    endtask

    task automatic run(input int n);
        int   k;
        ent_t e;
        k = 0;
        while (tq.size() > 0 && (n < 0 || k < n)) begin
            e = tq.pop_front();
            k++;
            mem_ready = e.rdy; br_taken = e.bt; inst = e.ins;
            @(negedge clk);
            chk("outputs", 64'(obs), 64'({e.st, e.stb, e.trp, e.cause}));
            chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
            chk("instret_cnt", 64'(instret_cnt), 64'(e.ret));
            @(posedge clk);
            #1;
        end
        if (tq.size() == 0) begin
            @(negedge clk);
            chk("final_cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
            chk("final_instret", 64'(instret_cnt), 64'(m_ret));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          t;
        logic [31:0] r;
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};

        do_reset();
        add_inst(32'h00500093, 0, 0, 1'b0, t);
        run(-1);

        do_reset();
        add_inst(32'h0040A103, 0, 3, 1'b0, t);
        run(-1);

        do_reset();
        add_inst(32'h00208463, 0, 0, 1'b0, t);
        add_inst(32'h00208463, 0, 0, 1'b1, t);
        run(-1);

        do_reset();
        add_illegal(32'h0000007F);
        run(-1);

        do_reset();
        add_inst(32'h00500093, TO, 0, 1'b0, t);
        run(-1);

        do_reset();
        add_inst(32'h00500093, TO - 1, 0, 1'b0, t);
        run(-1);

        do_reset();
        add_inst(32'h0020A223, 0, TO, 1'b0, t);
        run(-1);

        // Reset dropped asynchronously while a store waits in MEM
        do_reset();
        add_inst(32'h0020A223, 0, 6, 1'b0, t);
        run(5);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_in_mem", 64'({state, mem_req, mem_we}), 64'({S_MEM, 2'b11}));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'(obs), 64'd0);
        chk("abort_cycle_cnt", 64'(cycle_cnt), 64'd0);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            add_inst(rand_ins($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3), rb(), t);
        end
        run(-1);

        for (int rnd = 0; rnd < 6; rnd++) begin
            do_reset();
            t = 1'b0;
            for (int i = 0; i < 25 && !t; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    do r = rw(); while (cls_of(r[6:0]) >= 0);
                    add_illegal(r);
                    t = 1'b1;
                end else begin
                    add_inst(rand_ins($urandom_range(0, 7)), pick_wait(), pick_wait(), rb(), t);
                end
            end
            run(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
